ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-Lite style memory slave that sits directly downstream of the team's AHB master on the shared bus.
- Consumes HSEL/HADDR/HWRITE/HSIZE/HTRANS/HREADY/HWDATA.
- Returns hreadyout/hresp/HRDATA back to the master.
- Backs a word-organised SRAM with byte-lane writes, programmable wait states and a two-cycle ERROR response for bad accesses.
- One instance is placed per slave index.

Parameters:
- ADDR_WIDTH, 32: bus address width.
- DATA_WIDTH, 32: bus data width; must be 32 or 64.
- SLAVES_NUM, 4: number of slaves; sets the HSEL width to $clog2(SLAVES_NUM).
- SLAVE_ID, 0: HSEL index this instance responds to.
- MEM_DEPTH, 256: number of DATA_WIDTH words; must be a power of 2.
- WAIT_STATES, 1: HREADYOUT-low cycles inserted per OKAY transfer; 0 gives zero-wait.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  $clog2(SLAVES_NUM)  slave index from the master.
- HADDR  in  ADDR_WIDTH  byte address.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  transfer size (0=byte, 1=half, 2=word, 3=dword).
- HTRANS  in  2  transfer type.
- HREADY  in  1  bus ready; address phase is valid only when high.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADYOUT  out  1  slave ready; low inserts a wait.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  DATA_WIDTH  read data, valid when HREADYOUT=1 in a read data phase.

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK.
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM=IDLE, wait counter=0, all captured address-phase registers=0.
  - Memory contents are not reset.
- Accept rule: a transfer is accepted on a rising edge when HSEL==SLAVE_ID and HREADY=1 and the transfer-qualify condition is true (see Optional Feature).
  - On acceptance, capture HADDR, HWRITE and HSIZE into data-phase registers.
- Error check, done at accept:
  - Error if word index HADDR>>$clog2(DATA_WIDTH/8) >= MEM_DEPTH.
  - Error if HSIZE > $clog2(DATA_WIDTH/8).
  - Error if HADDR is not aligned to 2^HSIZE.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
    - Good access with WAIT_STATES>0: go to WAIT, counter=WAIT_STATES-1.
    - Good access with WAIT_STATES=0: the data phase completes in the next cycle; stay in IDLE.
    - Error access: go to ERR1.
  - WAIT: HREADYOUT=0.
    - Counter decrements each cycle.
    - At 0, go to IDLE; the next cycle is the completing data cycle (HREADYOUT=1).
    - New address phases are not accepted while HREADYOUT=0, because HREADY is low.
  - ERR1: HREADYOUT=0, HRESP=1; then go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1.
    - The memory is not touched.
    - Return to IDLE, or re-accept if a new valid address phase is present.
- Write commit:
  - Happens at the edge ending the data phase (HREADYOUT=1, OKAY).
  - Byte enables come from captured HSIZE and HADDR low bits.
  - Only the addressed lanes of HWDATA are written; other bytes are preserved.
- Read data:
  - HRDATA = mem[captured index] during a read data phase, driven by the register at completion.
  - HRDATA holds its last value otherwise.
  - Byte and half reads return the full word; the master selects lanes.
- Pipelining:
  - A new address phase may be accepted in the same cycle a data phase completes.
  - Back-to-back zero-wait transfers run at 1/cycle.
- Read-after-write to the same word, back-to-back, must return the newly written data: bypass when the write commits on the same edge the read data is registered.
- Deselect: HSEL!=SLAVE_ID or HREADY=0 gives no accept. An in-flight data phase still completes normally.
- Reset mid-transfer: the FSM is forced to IDLE, the pending write is dropped, and outputs go to their reset values immediately.

Optional Feature:
- Macro: AHB_SLAVE_HTRANS_CHECK_EN.
- Defined: qualify = HTRANS is NONSEQ(2'b10) or SEQ(2'b11). IDLE and BUSY get a zero-wait OKAY and no memory access.
- Undefined: qualify = 1. Any selected HREADY=1 cycle is a transfer, which is compatible with masters that leave HTRANS at 2'b00.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE codes.
  - HRESP codes OKAY/ERROR.
  - The slave FSM state encoding.
- Sub-module ahb_sram_mem: synchronous-write word array with per-byte write enables and asynchronous read port, parameterised by DATA_WIDTH and MEM_DEPTH.

Test Plan:
- WAIT_STATES=1, write word 0xDEADBEEF @0x10, then read @0x10 -> one HREADYOUT-low cycle each; HRDATA=0xDEADBEEF with HRESP=0.
- WAIT_STATES=0, back-to-back write 0x11223344 @0x20 then read @0x20 -> read completes next cycle with 0x11223344 (bypass path).
- Byte write 0xAB @0x21 after the above, then read @0x20 -> HRDATA=0x1122AB44.
- Read @ MEM_DEPTH*4 (0x400) -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
- Half-word write @0x23 (misaligned) -> ERROR sequence, no write; a subsequent read @0x20 is unchanged.
- Assert HRESETn low during WAIT of a write 0x55 @0x30 -> outputs go to reset values asynchronously; read @0x30 after release shows the old value, not 0x55. HSEL=SLAVE_ID+1 traffic gets no response.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes and slave FSM encoding.
// Imported by the SRAM slave and its word array.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

    // Lane mask for an aligned transfer of 2^size bytes at byte offset off.
    function automatic logic [7:0] byte_en(
        input logic [2:0] size,
        input logic [2:0] off
    );
        logic [7:0] m;
        unique case (size)
            HSIZE_BYTE: m = 8'h01;
            HSIZE_HALF: m = 8'h03;
            HSIZE_WORD: m = 8'h0F;
            default:    m = 8'hFF;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM: synchronous byte-lane write,
// asynchronous read. Contents are never reset.
module ahb_sram_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_widx,
    input  logic [DATA_WIDTH/8-1:0]      i_be,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_ridx,
    output logic [DATA_WIDTH-1:0]        o_rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with wait states and two-cycle ERROR.
// AHB_SLAVE_HTRANS_CHECK_EN: only NONSEQ/SEQ count as transfers.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SLAVES_NUM  = 4,
    parameter int SLAVE_ID    = 0,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [$clog2(SLAVES_NUM)-1:0] HSEL,
    input  logic [ADDR_WIDTH-1:0]         HADDR,
    input  logic                          HWRITE,
    input  logic [2:0]                    HSIZE,
    input  logic [1:0]                    HTRANS,
    input  logic                          HREADY,
    input  logic [DATA_WIDTH-1:0]         HWDATA,
    output logic                          HREADYOUT,
    output logic                          HRESP,
    output logic [DATA_WIDTH-1:0]         HRDATA
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam int SW  = $clog2(SLAVES_NUM);
    localparam int CW  = 16;

    slv_state_e            r_state;
    slv_state_e            w_state_nx;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic                  r_dp;
    logic [DATA_WIDTH-1:0] r_hrdata;

    logic                  w_qual;
    logic                  w_take;
    logic                  w_err;
    logic                  w_al_err;
    logic                  w_ready;
    logic                  w_resp;
    logic                  w_done;
    logic                  w_commit;
    logic                  w_rd_load;
    logic                  w_byp;
    logic [IW-1:0]         w_widx;
    logic [IW-1:0]         w_ridx;
    logic [7:0]            w_be8;
    logic [NB-1:0]         w_be;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_unused;

`ifdef AHB_SLAVE_HTRANS_CHECK_EN
    assign w_qual = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
`else
    assign w_qual = 1'b1;
`endif

    assign w_unused = &{1'b0, HTRANS, r_addr[ADDR_WIDTH-1:LSB+IW]};

    assign w_take = (HSEL == SW'(SLAVE_ID)) && HREADY && w_qual && w_ready;

    always_comb begin
        w_al_err = 1'b0;
        unique case (HSIZE)
            HSIZE_BYTE: w_al_err = 1'b0;
            HSIZE_HALF: w_al_err = HADDR[0];
            HSIZE_WORD: w_al_err = |HADDR[1:0];
            default:    w_al_err = |HADDR[2:0];
        endcase
    end

    assign w_err = (|HADDR[ADDR_WIDTH-1:LSB+IW])
                 | (HSIZE > 3'(LSB))
                 | w_al_err;

    // The single IDLE cycle after an accepted OKAY access closes it.
    assign w_done   = (r_state == ST_IDLE) && r_dp;
    assign w_commit = w_done && r_write;
    assign w_widx   = r_addr[LSB +: IW];
    assign w_be8    = byte_en(r_size, 3'(r_addr[LSB-1:0]));
    assign w_be     = w_be8[NB-1:0];

    // Read data is registered on the edge that opens the completing cycle.
    assign w_ridx    = (WAIT_STATES == 0) ? HADDR[LSB +: IW] : w_widx;
    assign w_rd_load = (WAIT_STATES == 0)
                     ? (w_take && !w_err && !HWRITE)
                     : ((r_state == ST_WAIT) && (r_cnt == '0) && !r_write);
    assign w_byp     = w_commit && (w_ridx == w_widx);

    always_comb begin
        w_rd_word = w_mem_rdata;
        if (w_byp) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_state_nx = ST_IDLE;
                if (w_take) begin
                    if (w_err) begin
                        w_state_nx = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nx = ST_WAIT;
                        w_cnt_nx   = CW'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            ST_ERR1: w_state_nx = ST_ERR2;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b1;
        w_resp  = HRESP_OKAY;
        unique case (r_state)
            ST_IDLE: w_ready = 1'b1;
            ST_WAIT: w_ready = 1'b0;
            ST_ERR1: begin
                w_ready = 1'b0;
                w_resp  = HRESP_ERROR;
            end
            ST_ERR2: w_resp = HRESP_ERROR;
            default: w_ready = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_dp     <= 1'b0;
            r_hrdata <= '0;
        end else begin
            if (w_take) begin
                r_addr  <= HADDR;
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_dp    <= !w_err;
            end else if (w_done) begin
                r_dp <= 1'b0;
            end
            if (w_rd_load) begin
                r_hrdata <= w_rd_word;
            end
        end
    end

    ahb_sram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .i_clk   (HCLK),
        .i_we    (w_commit),
        .i_widx  (w_widx),
        .i_be    (w_be),
        .i_wdata (HWDATA),
        .i_ridx  (w_ridx),
        .o_rdata (w_mem_rdata)
    );

    assign HREADYOUT = w_ready;
    assign HRESP     = w_resp;
    assign HRDATA    = r_hrdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one-wait and zero-wait instances
// driven by a pipelined master against a word-array model.
module tb_ahb_sram_slave;

    typedef struct {
        bit          sel;
        bit          wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] dat;
        bit          eerr;
        logic [31:0] erd;
    } xfer_t;

    typedef struct {
        int          d;
        bit          sel;
        bit          wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] dat;
        bit          eerr;
        logic [31:0] erd;
    } vec_t;

    logic        clk;
    logic        hresetn;
    logic [1:0]  hsel      [2];
    logic [31:0] haddr     [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [1:0]  htrans    [2];
    logic        hready    [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [2][256];
    xfer_t       q [$];

    ahb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVES_NUM(4),
        .SLAVE_ID(1), .MEM_DEPTH(256), .WAIT_STATES(1)
    ) dut0 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[0]),
        .HADDR(haddr[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
        .HTRANS(htrans[0]), .HREADY(hready[0]), .HWDATA(hwdata[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVES_NUM(4),
        .SLAVE_ID(2), .MEM_DEPTH(256), .WAIT_STATES(0)
    ) dut1 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[1]),
        .HADDR(haddr[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
        .HTRANS(htrans[1]), .HREADY(hready[1]), .HWDATA(hwdata[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] sid(input int d);
        return (d == 0) ? 2'd1 : 2'd2;
    endfunction

    function automatic int ws(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] a,
                       input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s d=%0d addr=%h: got %h want %h", nm, d, a, act, exp);
        end
    endtask

    // Model: apply the access to the word array, return what the bus must show.
    function automatic xfer_t mk(input int d, input bit sel, input bit wr,
                                 input logic [2:0] sz, input logic [31:0] a,
                                 input logic [31:0] dat);
        xfer_t x;
        int    off;
        int    idx;
        x.sel  = sel;
        x.wr   = wr;
        x.sz   = sz;
        x.a    = a;
        x.dat  = dat;
        x.eerr = ((a >> 2) >= 32'd256) || (sz > 3'd2)
               || ((a % (32'd1 << sz)) != 32'd0);
        x.erd  = 32'h0;
        if (sel && !x.eerr) begin
            off = int'(a % 4);
            idx = int'(a >> 2);
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (b >= off && b < off + (1 << sz)) begin
                        mdl[d][idx][8*b +: 8] = dat[8*b +: 8];
                    end
                end
            end else begin
                x.erd = mdl[d][idx];
            end
        end
        return x;
    endfunction

    task automatic drive_idle(input int d);
        hsel[d]   = sid(d) + 2'd1;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
    endtask

    // Pipelined master: address of the next transfer overlaps the current data phase.
    task automatic run(input int d);
        xfer_t ap;
        xfer_t dp;
        bit    have_ap = 0;
        bit    have_dp = 0;
        bit    acc     = 0;
        bit    seen_err = 0;
        int    waits   = 0;
        int    guard   = 0;
        logic  rdy;
        while ((q.size() > 0 || have_ap || have_dp) && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (acc) begin
                if (have_ap) begin
                    dp       = ap;
                    have_dp  = 1;
                    waits    = 0;
                    seen_err = 0;
                    hwdata[d] = dp.wr ? dp.dat : $urandom;
                end
                have_ap = 0;
            end
            rdy = hreadyout[d];
            if (have_dp) begin
                if (rdy) begin
                    if (dp.eerr)
                        chk("err_rsp", d, dp.a, {waits[7:0], seen_err, hresp[d]},
                            {8'd1, 1'b1, 1'b1});
                    else
                        chk("ok_rsp", d, dp.a, {waits[7:0], seen_err, hresp[d]},
                            {8'(ws(d)), 1'b0, 1'b0});
                    if (!dp.wr && !dp.eerr)
                        chk("rdata", d, dp.a, hrdata[d], dp.erd);
                    have_dp = 0;
                end else begin
                    waits++;
                    if (hresp[d]) seen_err = 1;
                end
            end else begin
                chk("idle_rsp", d, haddr[d], {rdy, hresp[d]}, 2'b10);
            end
            if (rdy) begin
                if (q.size() > 0) begin
                    ap        = q.pop_front();
                    hsel[d]   = ap.sel ? sid(d) : sid(d) + 2'd1;
                    haddr[d]  = ap.a;
                    hwrite[d] = ap.wr;
                    hsize[d]  = ap.sz;
                    htrans[d] = 2'b10;
                    have_ap   = ap.sel;
                end else begin
                    drive_idle(d);
                end
            end
            hready[d] = rdy;
            acc       = rdy;
        end
        if (guard >= 5000) begin
            chk("timeout", d, 32'h0, 64'(guard), 64'd0);
            q.delete();
        end
    endtask

    vec_t tbl [20];
    int   nt;

    initial begin
        xfer_t x;
        int    off;
        logic [2:0]  sz;
        logic [31:0] a;

        hresetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive_idle(d);
            haddr[d]  = '0;
            hsize[d]  = 3'd2;
            hready[d] = 1'b1;
            hwdata[d] = '0;
        end

        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out", d, 32'h0, {hreadyout[d], hresp[d], hrdata[d]},
                {1'b1, 1'b0, 32'h0});
        end
        @(negedge clk);
        hresetn = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                q.push_back(mk(d, 1, 1, 3'd2, 32'(i) << 2,
                               {8'hC3, 8'(d), 8'(i), ~8'(i)}));
            end
            run(d);
        end

        nt = 0;
        tbl[nt++] = '{0, 1, 1, 3'd2, 32'h10,  32'hDEADBEEF, 0, 32'h0};
        tbl[nt++] = '{0, 1, 0, 3'd2, 32'h10,  32'h0,        0, 32'hDEADBEEF};
        tbl[nt++] = '{0, 0, 1, 3'd2, 32'h10,  32'h0,        0, 32'h0};
        tbl[nt++] = '{0, 1, 0, 3'd2, 32'h10,  32'h0,        0, 32'hDEADBEEF};
        tbl[nt++] = '{0, 1, 0, 3'd2, 32'h400, 32'h0,        1, 32'h0};
        tbl[nt++] = '{0, 1, 1, 3'd1, 32'h11,  32'hFFFFFFFF, 1, 32'h0};
        tbl[nt++] = '{0, 1, 0, 3'd2, 32'h10,  32'h0,        0, 32'hDEADBEEF};
        tbl[nt++] = '{1, 1, 1, 3'd2, 32'h20,  32'h11223344, 0, 32'h0};
        tbl[nt++] = '{1, 1, 0, 3'd2, 32'h20,  32'h0,        0, 32'h11223344};
        tbl[nt++] = '{1, 1, 1, 3'd0, 32'h21,  32'hFFFFABFF, 0, 32'h0};
        tbl[nt++] = '{1, 1, 0, 3'd2, 32'h20,  32'h0,        0, 32'h1122AB44};
        tbl[nt++] = '{1, 1, 0, 3'd2, 32'h400, 32'h0,        1, 32'h0};
        tbl[nt++] = '{1, 1, 1, 3'd1, 32'h23,  32'hFFFFFFFF, 1, 32'h0};
        tbl[nt++] = '{1, 1, 0, 3'd2, 32'h20,  32'h0,        0, 32'h1122AB44};
        tbl[nt++] = '{1, 1, 0, 3'd3, 32'h28,  32'h0,        1, 32'h0};
        tbl[nt++] = '{1, 1, 1, 3'd1, 32'h22,  32'hBEEF0000, 0, 32'h0};
        tbl[nt++] = '{1, 1, 0, 3'd2, 32'h20,  32'h0,        0, 32'hBEEFAB44};

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nt; i++) begin
                if (tbl[i].d == d) begin
                    x = mk(d, tbl[i].sel, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].dat);
                    x.eerr = tbl[i].eerr;
                    x.erd  = tbl[i].erd;
                    q.push_back(x);
                end
            end
            run(d);
        end

        // Reset in the wait cycle of a write: the write must never land.
        @(negedge clk);
        chk("pre_rdy", 0, 32'h30, {31'h0, hreadyout[0]}, 32'h1);
        hsel[0]   = sid(0);
        haddr[0]  = 32'h30;
        hwrite[0] = 1'b1;
        hsize[0]  = 3'd2;
        htrans[0] = 2'b10;
        hready[0] = 1'b1;
        @(negedge clk);
        drive_idle(0);
        hwdata[0] = 32'h55;
        hready[0] = 1'b0;
        chk("wait_lo", 0, 32'h30, {31'h0, hreadyout[0]}, 32'h0);
        #1 hresetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_mid", d, 32'h30, {hreadyout[d], hresp[d], hrdata[d]},
                {1'b1, 1'b0, 32'h0});
        end
        @(negedge clk);
        hresetn   = 1'b1;
        hready[0] = 1'b1;
        q.push_back(mk(0, 1, 0, 3'd2, 32'h30, 32'h0));
        run(0);
        q.push_back(mk(1, 1, 0, 3'd2, 32'h20, 32'h0));
        run(1);

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 200; k++) begin
                case ($urandom_range(0, 15))
                    0, 1, 2, 3, 4:      sz = 3'd0;
                    5, 6, 7, 8, 9:      sz = 3'd1;
                    10, 11, 12, 13, 14: sz = 3'd2;
                    default:            sz = 3'd3;
                endcase
                off = int'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
                if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
                else a = 32'($urandom_range(0, 255)) << 2;
                a = {a[31:2], 2'b00} | 32'(off);
                q.push_back(mk(d, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                               sz, a, $urandom));
            end
            run(d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
